// File: rtl/iic_slave_regs_if.sv
// Single-cycle register-file port between the I2C target and a local register bank.
// The bridge drives the pointer and write strobe; the bank returns combinational read data.
interface iic_slave_regs_if;
  logic [7:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       REG_WE;
  logic [7:0] REG_RDATA;

  modport master (output REG_ADDR, output REG_WDATA, output REG_WE, input REG_RDATA);
  modport slave  (input REG_ADDR, input REG_WDATA, input REG_WE, output REG_RDATA);
endinterface

// File: rtl/iic_slave_regs.sv
// Oversampling I2C target: [addr+W, sub, data...] writes and split reads onto a register port.
// state     | meaning
// IDLE      | bus free / after STOP           ADDR      | shifting address byte
// ADDR_ACK  | driving address ACK             SUB       | shifting register pointer
// SUB_ACK   | driving pointer ACK             WDATA     | shifting write data (burst)
// WDATA_ACK | driving data ACK                RDATA     | shifting read data out
// RDATA_ACK | sampling master ACK/NACK        IGNORE    | not addressed, wait START/STOP
module iic_slave_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h21,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             I2C_SCLK,
  inout  wire              I2C_SDAT,
  iic_slave_regs_if.master rbus,
  output logic             BUSY,
  output logic             ACK_ERR
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  localparam logic [2:0] FILT_TC = 3'(FILT_LEN - 1);

  // index 1 = SCL, index 0 = SDA
  logic [1:0] pin, sync1, sync2, filt, filt_q;
  logic [2:0] fcnt [2];
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_nxt;
  logic [3:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [6:0] tx_shift;
  logic       sda_oe, oe_nxt, byte_st;
  logic       cnt_clr, rx_en, wr_done, ld_sub, ld_tx, sh_tx, rd_inc;
  logic       busy_set, busy_clr, frame_err;

  assign pin      = {I2C_SCLK, I2C_SDAT};
  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_q  <= 2'b11;
      fcnt[0] <= FILT_TC;
      fcnt[1] <= FILT_TC;
    end else begin
      sync1  <= pin;
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= FILT_TC;
        end else if (fcnt[i] == 3'd0) begin
          filt[i] <= sync2[i];
          fcnt[i] <= FILT_TC;
        end else begin
          fcnt[i] <= fcnt[i] - 3'd1;
        end
      end
    end
  end

  assign scl_rise  =  filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] &  filt_q[1];
  assign start_det = ~filt[0] &  filt_q[0] & filt[1] & filt_q[1];
  assign stop_det  =  filt[0] & ~filt_q[0] & filt[1] & filt_q[1];
  assign byte_st   = (state == S_ADDR) || (state == S_SUB) || (state == S_WDATA) || (state == S_RDATA);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oe_nxt    = sda_oe;
    cnt_clr   = 1'b0;
    rx_en     = 1'b0;
    wr_done   = 1'b0;
    ld_sub    = 1'b0;
    ld_tx     = 1'b0;
    sh_tx     = 1'b0;
    rd_inc    = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
    frame_err = 1'b0;
    if (start_det || stop_det) begin
      // the SCL rise framing a START/STOP is counted too, so a cut byte shows 2..7
      frame_err = byte_st && (bit_cnt >= 4'd2) && (bit_cnt <= 4'd7);
      state_nxt = stop_det ? S_IDLE : S_ADDR;
      busy_clr  = stop_det;
      oe_nxt    = 1'b0;
      cnt_clr   = 1'b1;
    end else begin
      rx_en   = byte_st && scl_rise;
      wr_done = (state == S_WDATA) && scl_rise && (bit_cnt == 4'd7);
      case (state)
        S_ADDR, S_SUB, S_WDATA: begin
          if (scl_fall && bit_cnt == 4'd8) begin
            cnt_clr = 1'b1;
            if (state == S_ADDR) begin
              if (rx_shift[7:1] == SLAVE_ADDR) begin
                state_nxt = S_ADDR_ACK;
                oe_nxt    = 1'b1;
                busy_set  = 1'b1;
              end else begin
                state_nxt = S_IGNORE;
                busy_clr  = 1'b1;
              end
            end else begin
              state_nxt = (state == S_SUB) ? S_SUB_ACK : S_WDATA_ACK;
              ld_sub    = (state == S_SUB);
              oe_nxt    = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rx_shift[0]) begin
              state_nxt = S_RDATA;
              ld_tx     = 1'b1;
              oe_nxt    = ~rbus.REG_RDATA[7];
            end else begin
              state_nxt = S_SUB;
              oe_nxt    = 1'b0;
            end
          end
        end
        S_SUB_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_nxt = S_WDATA;
            oe_nxt    = 1'b0;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_nxt = S_RDATA_ACK;
              oe_nxt    = 1'b0;
              cnt_clr   = 1'b1;
              rd_inc    = 1'b1;
            end else begin
              sh_tx  = 1'b1;
              oe_nxt = ~tx_shift[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise && filt[0]) begin
            state_nxt = S_IGNORE;
          end else if (scl_fall) begin
            state_nxt = S_RDATA;
            ld_tx     = 1'b1;
            oe_nxt    = ~rbus.REG_RDATA[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bit_cnt        <= 4'd0;
      rx_shift       <= 8'h00;
      tx_shift       <= 7'h00;
      sda_oe         <= 1'b0;
      BUSY           <= 1'b0;
      ACK_ERR        <= 1'b0;
      rbus.REG_ADDR  <= 8'h00;
      rbus.REG_WDATA <= 8'h00;
      rbus.REG_WE    <= 1'b0;
    end else begin
      sda_oe      <= oe_nxt;
      ACK_ERR     <= frame_err;
      rbus.REG_WE <= wr_done;
      if (wr_done) rbus.REG_WDATA <= {rx_shift[6:0], filt[0]};
      if (cnt_clr) begin
        bit_cnt <= 4'd0;
      end else if (rx_en) begin
        bit_cnt  <= bit_cnt + 4'd1;
        rx_shift <= {rx_shift[6:0], filt[0]};
      end
      if (ld_tx)      tx_shift <= rbus.REG_RDATA[6:0];
      else if (sh_tx) tx_shift <= {tx_shift[5:0], 1'b0};
      if (busy_clr)      BUSY <= 1'b0;
      else if (busy_set) BUSY <= 1'b1;
      if (ld_sub)                       rbus.REG_ADDR <= rx_shift;
      else if (rbus.REG_WE || rd_inc)   rbus.REG_ADDR <= rbus.REG_ADDR + 8'd1;
    end
  end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench: bit-banged I2C master against iic_slave_regs with a simple register bank.
`timescale 1ns/1ps
module tb_iic_slave_regs;
  localparam int Q = 10;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  wire  sda_bus;
  logic BUSY, ACK_ERR;

  logic [7:0] regmem [256];
  logic [7:0] we_addr_log [64];
  logic [7:0] we_data_log [64];
  int errors = 0;
  int checks = 0;
  int we_total = 0;
  int err_total = 0;
  int drive_total = 0;

  iic_slave_regs_if rbus();

  always #5 iCLK = ~iCLK;

  assign sda_bus = sda_m ? 1'bz : 1'b0;
  pullup (sda_bus);
  assign rbus.REG_RDATA = regmem[rbus.REG_ADDR];

  iic_slave_regs #(.SLAVE_ADDR(7'h21), .FILT_LEN(3)) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .I2C_SCLK (scl_m),
    .I2C_SDAT (sda_bus),
    .rbus     (rbus),
    .BUSY     (BUSY),
    .ACK_ERR  (ACK_ERR)
  );

  always @(negedge iCLK) begin
    if (rbus.REG_WE) begin
      we_addr_log[we_total[5:0]] <= rbus.REG_ADDR;
      we_data_log[we_total[5:0]] <= rbus.REG_WDATA;
      we_total <= we_total + 1;
    end
    if (ACK_ERR) err_total <= err_total + 1;
    if (sda_m && sda_bus === 1'b0) drive_total <= drive_total + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic send_bit(input logic b, input logic glitch, output logic s);
    sda_m = b;
    if (glitch) begin
      tick(Q / 2);
      scl_m = 1'b1;
      tick(1);
      scl_m = 1'b0;
      tick(Q - Q / 2 - 1);
    end else begin
      tick(Q);
    end
    scl_m = 1'b1;
    tick(Q);
    s = sda_bus;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) send_bit(d[7-i], (i == glitch_bit), s);
    send_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    send_bit(mack, 1'b0, s);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    tick(4);
    checks++; if (rbus.REG_ADDR !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", rbus.REG_ADDR); end
    checks++; if (rbus.REG_WDATA !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h want 00", rbus.REG_WDATA); end
    checks++; if (rbus.REG_WE !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", rbus.REG_WE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    checks++; if (ACK_ERR !== 1'b0) begin errors++; $display("FAIL rst_ackerr: got %b want 0", ACK_ERR); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rst_sda: got %b want 1", sda_bus); end
    iRST = 1'b0;
    tick(10);
  endtask

  task automatic test_write();
    int wb, eb, nack;
    logic a;
    wb = we_total; eb = err_total; nack = 0;
    i2c_start();
    send_byte(8'h42, -1, a); if (a !== 1'b0) nack++;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", BUSY); end
    send_byte(8'h10, -1, a); if (a !== 1'b0) nack++;
    send_byte(8'hA5, -1, a); if (a !== 1'b0) nack++;
    i2c_stop();
    tick(Q);
    checks++; if (nack != 0) begin errors++; $display("FAIL wr_acks: got %0d missing want 0", nack); end
    checks++; if (we_total - wb != 1) begin errors++; $display("FAIL wr_we_count: got %0d want 1", we_total - wb); end
    checks++; if (we_addr_log[wb[5:0]] !== 8'h10) begin errors++; $display("FAIL wr_we_addr: got %h want 10", we_addr_log[wb[5:0]]); end
    checks++; if (we_data_log[wb[5:0]] !== 8'hA5) begin errors++; $display("FAIL wr_we_data: got %h want a5", we_data_log[wb[5:0]]); end
    checks++; if (rbus.REG_ADDR !== 8'h11) begin errors++; $display("FAIL wr_addr_after: got %h want 11", rbus.REG_ADDR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL wr_busy_stop: got %b want 0", BUSY); end
    checks++; if (err_total - eb != 0) begin errors++; $display("FAIL wr_ackerr: got %0d want 0", err_total - eb); end
  endtask

  task automatic test_split_read();
    int wb, nack;
    logic a;
    logic [7:0] d;
    wb = we_total; nack = 0;
    i2c_start();
    send_byte(8'h42, -1, a); if (a !== 1'b0) nack++;
    send_byte(8'h10, -1, a); if (a !== 1'b0) nack++;
    i2c_stop();
    tick(Q);
    i2c_start();
    send_byte(8'h43, -1, a); if (a !== 1'b0) nack++;
    read_byte(1'b1, d);
    i2c_stop();
    tick(Q);
    checks++; if (nack != 0) begin errors++; $display("FAIL rd_acks: got %0d missing want 0", nack); end
    checks++; if (d !== 8'h5C) begin errors++; $display("FAIL rd_data: got %h want 5c", d); end
    checks++; if (rbus.REG_ADDR !== 8'h11) begin errors++; $display("FAIL rd_addr_after: got %h want 11", rbus.REG_ADDR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rd_busy: got %b want 0", BUSY); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rd_sda_released: got %b want 1", sda_bus); end
    checks++; if (we_total - wb != 0) begin errors++; $display("FAIL rd_no_we: got %0d want 0", we_total - wb); end
  endtask

  task automatic test_burst_wrap();
    int wb, nack;
    logic a;
    logic [7:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a = '{8'hFE, 8'hFF, 8'h00};
    exp_d = '{8'h01, 8'h02, 8'h03};
    wb = we_total; nack = 0;
    i2c_start();
    send_byte(8'h42, -1, a); if (a !== 1'b0) nack++;
    send_byte(8'hFE, -1, a); if (a !== 1'b0) nack++;
    for (int i = 0; i < 3; i++) begin
      send_byte(exp_d[i], -1, a); if (a !== 1'b0) nack++;
    end
    i2c_stop();
    tick(Q);
    checks++; if (nack != 0) begin errors++; $display("FAIL bw_acks: got %0d missing want 0", nack); end
    checks++; if (we_total - wb != 3) begin errors++; $display("FAIL bw_we_count: got %0d want 3", we_total - wb); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (we_addr_log[(wb + i) % 64] !== exp_a[i] || we_data_log[(wb + i) % 64] !== exp_d[i]) begin
        errors++;
        $display("FAIL bw_write%0d: got %h@%h want %h@%h", i, we_data_log[(wb + i) % 64],
                 we_addr_log[(wb + i) % 64], exp_d[i], exp_a[i]);
      end
    end
    checks++; if (rbus.REG_ADDR !== 8'h01) begin errors++; $display("FAIL bw_addr_after: got %h want 01", rbus.REG_ADDR); end
  endtask

  task automatic test_mismatch();
    int wb, db;
    logic a, a2;
    wb = we_total; db = drive_total;
    i2c_start();
    send_byte(8'h44, -1, a);
    send_byte(8'h55, -1, a2);
    i2c_stop();
    tick(Q);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL mm_addr_ack: got %b want 1", a); end
    checks++; if (drive_total - db != 0) begin errors++; $display("FAIL mm_sda_driven: got %0d cycles want 0", drive_total - db); end
    checks++; if (we_total - wb != 0) begin errors++; $display("FAIL mm_we: got %0d want 0", we_total - wb); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mm_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_rstart_err();
    int wb, eb;
    logic a, s;
    wb = we_total; eb = err_total;
    i2c_start();
    send_byte(8'h42, -1, a);
    send_byte(8'h20, -1, a);
    send_bit(1'b1, 1'b0, s);
    send_bit(1'b0, 1'b0, s);
    send_bit(1'b1, 1'b0, s);
    send_bit(1'b0, 1'b0, s);
    i2c_start();
    checks++; if (err_total - eb != 1) begin errors++; $display("FAIL rs_ackerr: got %0d want 1", err_total - eb); end
    send_byte(8'h42, -1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rs_new_addr_ack: got %b want 0", a); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rs_busy: got %b want 1", BUSY); end
    i2c_stop();
    tick(Q);
    checks++; if (we_total - wb != 0) begin errors++; $display("FAIL rs_no_we: got %0d want 0", we_total - wb); end
    checks++; if (rbus.REG_ADDR !== 8'h20) begin errors++; $display("FAIL rs_addr: got %h want 20", rbus.REG_ADDR); end
    checks++; if (err_total - eb != 1) begin errors++; $display("FAIL rs_ackerr_total: got %0d want 1", err_total - eb); end
  endtask

  task automatic test_reset_mid_read();
    int wb, nack;
    logic a, s;
    logic [6:0] bits;
    nack = 0;
    i2c_start();
    send_byte(8'h43, -1, a); if (a !== 1'b0) nack++;
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b1, 1'b0, s);
      bits = {bits[5:0], s};
    end
    checks++; if (bits !== 7'h7F) begin errors++; $display("FAIL rr_bits: got %h want 7f", bits); end
    checks++; if (sda_bus !== 1'b0) begin errors++; $display("FAIL rr_bit0_driven: got %b want 0", sda_bus); end
    iRST = 1'b1;
    tick(1);
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rr_sda_release: got %b want 1", sda_bus); end
    tick(2);
    checks++; if (rbus.REG_ADDR !== 8'h00) begin errors++; $display("FAIL rr_addr: got %h want 00", rbus.REG_ADDR); end
    checks++; if (rbus.REG_WDATA !== 8'h00) begin errors++; $display("FAIL rr_wdata: got %h want 00", rbus.REG_WDATA); end
    checks++; if (BUSY !== 1'b0 || rbus.REG_WE !== 1'b0 || ACK_ERR !== 1'b0) begin
      errors++; $display("FAIL rr_flags: got busy=%b we=%b err=%b want 0 0 0", BUSY, rbus.REG_WE, ACK_ERR);
    end
    iRST = 1'b0;
    tick(2);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(2 * Q);
    wb = we_total;
    i2c_start();
    send_byte(8'h42, -1, a); if (a !== 1'b0) nack++;
    send_byte(8'h40, -1, a); if (a !== 1'b0) nack++;
    send_byte(8'h3C, 3, a); if (a !== 1'b0) nack++;
    i2c_stop();
    tick(Q);
    checks++; if (nack != 0) begin errors++; $display("FAIL gl_acks: got %0d missing want 0", nack); end
    checks++; if (we_total - wb != 1) begin errors++; $display("FAIL gl_we_count: got %0d want 1", we_total - wb); end
    checks++; if (we_addr_log[wb[5:0]] !== 8'h40 || we_data_log[wb[5:0]] !== 8'h3C) begin
      errors++; $display("FAIL gl_write: got %h@%h want 3c@40", we_data_log[wb[5:0]], we_addr_log[wb[5:0]]);
    end
    checks++; if (rbus.REG_ADDR !== 8'h41) begin errors++; $display("FAIL gl_addr_after: got %h want 41", rbus.REG_ADDR); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) regmem[i] = 8'(i) ^ 8'h96;
    regmem[8'h10] = 8'h5C;
    regmem[8'h20] = 8'hFE;
    test_reset();
    test_write();
    test_split_read();
    test_burst_wrap();
    test_mismatch();
    test_rstart_err();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
